// File: rtl/com_link_pkg.sv
// Shared types for the host-link controller: status codes, FSM states and widths.
package com_link_pkg;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;
  localparam int IDX_W  = WORD_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_LOAD     = 2'b01,
    ST_RUN      = 2'b10,
    ST_READBACK = 2'b11
  } status_e;

  typedef enum logic [3:0] {
    S_IDLE, S_CNT_HI, S_DAT_LO, S_DAT_HI, S_WRITE,
    S_RUN, S_RD_ADDR, S_TX_LO, S_TX_HI, S_FIN
  } state_e;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic              wr_en;
  } dm_req_t;

  function automatic status_e status_of(state_e s);
    case (s)
      S_DAT_LO, S_DAT_HI, S_WRITE:  status_of = ST_LOAD;
      S_RUN:                        status_of = ST_RUN;
      S_RD_ADDR, S_TX_LO, S_TX_HI:  status_of = ST_READBACK;
      default:                      status_of = ST_IDLE;
    endcase
  endfunction
endpackage

// File: rtl/com_link_ctrl_if.sv
// Serial rx/tx handshakes, data-memory port and global status of the host link.
interface com_link_ctrl_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  status;
  logic [15:0] com_addr;
  logic [15:0] com_data_in;
  logic        com_wr_en;
  logic [15:0] com_data_out;
  logic        end_process;
  logic        done;

  modport master (
    input  rx_data, rx_valid, tx_ready, com_data_out, end_process,
    output rx_ready, tx_data, tx_valid, status, com_addr, com_data_in, com_wr_en, done
  );
  modport slave (
    output rx_data, rx_valid, tx_ready, com_data_out, end_process,
    input  rx_ready, tx_data, tx_valid, status, com_addr, com_data_in, com_wr_en, done
  );
endinterface

// File: rtl/byte_word_pack.sv
// Assembles rx byte pairs into a word and serialises a held word for tx, lo byte first.
module byte_word_pack
  import com_link_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_take_i,
  input  logic [BYTE_W-1:0] rx_byte_i,
  input  logic              hold_load_i,
  input  logic [WORD_W-1:0] hold_word_i,
  input  logic              tx_take_i,
  output logic [WORD_W-1:0] word_o,
  output logic [BYTE_W-1:0] tx_byte_o
);
  logic              phase_q;
  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] hold_q;

  // rx and tx never overlap, so one phase bit tracks whichever lane is active
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      word_q  <= '0;
      hold_q  <= '0;
    end else begin
      phase_q <= phase_q ^ (rx_take_i | tx_take_i);
      if (rx_take_i) begin
        if (phase_q) word_q[WORD_W-1:BYTE_W] <= rx_byte_i;
        else         word_q[BYTE_W-1:0]      <= rx_byte_i;
      end
      if (hold_load_i) hold_q <= hold_word_i;
    end
  end

  assign word_o    = word_q;
  assign tx_byte_o = phase_q ? hold_q[WORD_W-1:BYTE_W] : hold_q[BYTE_W-1:0];
endmodule

// File: rtl/com_link_ctrl.sv
// Host-link controller: loads DM from a framed byte stream, runs the cores, streams results back.
module com_link_ctrl
  import com_link_pkg::*;
#(
  parameter logic [WORD_W-1:0] LOAD_BASE   = 16'h0000,
  parameter logic [WORD_W-1:0] RD_BASE     = 16'h0000,
  parameter int                RD_LAT      = 1,
  parameter int                RUN_HOLDOFF = 4
) (
  input logic             clk,
  input logic             rst_n,
  com_link_ctrl_if.master link
);
  localparam int          HO_LAST_I = (RUN_HOLDOFF > 0) ? RUN_HOLDOFF - 1 : 0;
  localparam logic [15:0] HO_LAST   = HO_LAST_I[15:0];

  state_e            state_q, state_d;
  status_e           status_q;
  dm_req_t           dm_q, dm_d;
  logic [WORD_W-1:0] n_q, n_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [15:0]       ho_q, ho_d;
  logic              rx_ready_q, tx_valid_q, done_q;
  logic [RD_LAT:0]   vld_pipe;
  logic              rx_fire, tx_fire, rd_start, wr_start, rx_take, hold_load;
  logic [WORD_W-1:0] word;
  logic [BYTE_W-1:0] tx_byte;

  assign rx_fire   = link.rx_valid & rx_ready_q;
  assign tx_fire   = tx_valid_q & link.tx_ready;
  assign rx_take   = rx_fire & ((state_q == S_DAT_LO) | (state_q == S_DAT_HI));
  assign hold_load = (state_q == S_RD_ADDR) & vld_pipe[RD_LAT];
  assign rd_start  = (state_d == S_RD_ADDR) & (state_q != S_RD_ADDR);
  assign wr_start  = (state_d == S_WRITE) & (state_q != S_WRITE);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    ho_d    = ho_q;
    case (state_q)
      S_IDLE: if (rx_fire) begin
        n_d[BYTE_W-1:0] = link.rx_data;
        idx_d           = '0;
        state_d         = S_CNT_HI;
      end
      S_CNT_HI: if (rx_fire) begin
        n_d[WORD_W-1:BYTE_W] = link.rx_data;
        ho_d                 = '0;
        state_d              = (n_d == '0) ? S_RUN : S_DAT_LO;
      end
      S_DAT_LO: if (rx_fire) state_d = S_DAT_HI;
      S_DAT_HI: if (rx_fire) state_d = S_WRITE;
      S_WRITE: begin
        idx_d   = idx_q + 1'b1;
        ho_d    = '0;
        state_d = (idx_d < {1'b0, n_q}) ? S_DAT_LO : S_RUN;
      end
      // end_process is only honoured from the last holdoff cycle onward
      S_RUN: begin
        if (ho_q != HO_LAST) ho_d = ho_q + 1'b1;
        else if (link.end_process) begin
          idx_d   = '0;
          state_d = (n_q == '0) ? S_FIN : S_RD_ADDR;
        end
      end
      S_RD_ADDR: if (vld_pipe[RD_LAT]) state_d = S_TX_LO;
      S_TX_LO:   if (tx_fire) state_d = S_TX_HI;
      S_TX_HI: if (tx_fire) begin
        idx_d   = idx_q + 1'b1;
        state_d = (idx_d < {1'b0, n_q}) ? S_RD_ADDR : S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // com_addr only moves on entry to WRITE or RD_ADDR
  always_comb begin
    dm_d       = dm_q;
    dm_d.wr_en = (state_d == S_WRITE);
    if (wr_start) dm_d.addr = LOAD_BASE + idx_d[WORD_W-1:0];
    if (rd_start) dm_d.addr = RD_BASE + idx_d[WORD_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      status_q   <= ST_IDLE;
      dm_q       <= '0;
      n_q        <= '0;
      idx_q      <= '0;
      ho_q       <= '0;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      vld_pipe   <= '0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_of(state_d);
      dm_q       <= dm_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      ho_q       <= ho_d;
      rx_ready_q <= state_d inside {S_IDLE, S_CNT_HI, S_DAT_LO, S_DAT_HI};
      tx_valid_q <= state_d inside {S_TX_LO, S_TX_HI};
      done_q     <= (state_d == S_FIN);
      vld_pipe   <= {vld_pipe[RD_LAT-1:0], rd_start};
    end
  end

  byte_word_pack u_pack (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_take_i  (rx_take),
    .rx_byte_i  (link.rx_data),
    .hold_load_i(hold_load),
    .hold_word_i(link.com_data_out),
    .tx_take_i  (tx_fire),
    .word_o     (word),
    .tx_byte_o  (tx_byte)
  );

  assign link.rx_ready    = rx_ready_q;
  assign link.tx_valid    = tx_valid_q;
  assign link.tx_data     = tx_byte;
  assign link.status      = status_q;
  assign link.com_addr    = dm_q.addr;
  assign link.com_wr_en   = dm_q.wr_en;
  assign link.com_data_in = word;
  assign link.done        = done_q;
endmodule

// File: tb/tb_com_link_ctrl.sv
// Directed bench: load, holdoff, readback, empty frame, address wrap and mid-frame reset.
module tb_com_link_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  com_link_ctrl_if lnk ();
  com_link_ctrl_if lnk_b ();

  com_link_ctrl u_dut (.clk(clk), .rst_n(rst_n), .link(lnk));
  com_link_ctrl #(.LOAD_BASE(16'hFFFF)) u_dut_b (.clk(clk), .rst_n(rst_n), .link(lnk_b));

  int n_tests, n_fail;
  int wr_cnt, wr_cnt_b, tx_cnt, done_cnt;
  logic [15:0] mem [0:3];
  logic [15:0] wr_addr [0:15];
  logic [15:0] wr_data [0:15];
  logic [15:0] wr_addr_b [0:15];
  logic [15:0] wr_data_b [0:15];
  logic [7:0]  tx_log [0:15];

  // DM model (1-cycle synchronous read) plus write/tx/done logging
  always @(posedge clk) begin
    lnk.com_data_out <= mem[lnk.com_addr[1:0]];
    if (lnk.com_wr_en) begin
      wr_addr[wr_cnt % 16] = lnk.com_addr;
      wr_data[wr_cnt % 16] = lnk.com_data_in;
      mem[lnk.com_addr[1:0]] = lnk.com_data_in;
      wr_cnt++;
    end
    if (lnk_b.com_wr_en) begin
      wr_addr_b[wr_cnt_b % 16] = lnk_b.com_addr;
      wr_data_b[wr_cnt_b % 16] = lnk_b.com_data_in;
      wr_cnt_b++;
    end
    if (lnk.tx_valid && lnk.tx_ready) begin
      tx_log[tx_cnt % 16] = lnk.tx_data;
      tx_cnt++;
    end
    if (lnk.done) done_cnt++;
  end

  always @(negedge clk) lnk.tx_ready = ($urandom_range(0, 1) == 1);

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    lnk.rx_valid = 1'b1;
    lnk.rx_data  = b;
    while (!lnk.rx_ready && t < 50) begin @(negedge clk); t++; end
    n_tests++;
    if (t >= 50) begin n_fail++; $display("FAIL rx_timeout byte=%h", b); end
    @(negedge clk);
    lnk.rx_valid = 1'b0;
  endtask

  task automatic send_byte_b(input logic [7:0] b);
    int t = 0;
    lnk_b.rx_valid = 1'b1;
    lnk_b.rx_data  = b;
    while (!lnk_b.rx_ready && t < 50) begin @(negedge clk); t++; end
    n_tests++;
    if (t >= 50) begin n_fail++; $display("FAIL rx_b_timeout byte=%h", b); end
    @(negedge clk);
    lnk_b.rx_valid = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int t = 0;
    while (!lnk.done && t < lim) begin @(negedge clk); t++; end
    n_tests++;
    if (!lnk.done) begin n_fail++; $display("FAIL done_timeout after %0d cycles", t); end
  endtask

  task automatic test_reset();
    lnk.rx_valid = 1'b0; lnk.rx_data = 8'h00; lnk.end_process = 1'b0;
    lnk_b.rx_valid = 1'b0; lnk_b.rx_data = 8'h00; lnk_b.end_process = 1'b0;
    lnk_b.tx_ready = 1'b0; lnk_b.com_data_out = 16'h0000;
    #12;
    n_tests++; if (lnk.status !== 2'b00) begin n_fail++; $display("FAIL rst_status act=%h exp=0", lnk.status); end
    n_tests++; if (lnk.rx_ready !== 1'b0) begin n_fail++; $display("FAIL rst_rx_ready act=%b exp=0", lnk.rx_ready); end
    n_tests++; if (lnk.tx_valid !== 1'b0 || lnk.tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx act=%b/%h exp=0/00", lnk.tx_valid, lnk.tx_data); end
    n_tests++; if (lnk.com_wr_en !== 1'b0 || lnk.done !== 1'b0) begin n_fail++; $display("FAIL rst_strobes wr=%b done=%b exp=0/0", lnk.com_wr_en, lnk.done); end
    n_tests++; if (lnk.com_addr !== 16'h0 || lnk.com_data_in !== 16'h0) begin n_fail++; $display("FAIL rst_dm addr=%h data=%h exp=0/0", lnk.com_addr, lnk.com_data_in); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (lnk.rx_ready !== 1'b1) begin n_fail++; $display("FAIL idle_rx_ready act=%b exp=1", lnk.rx_ready); end
  endtask

  task automatic test_load();
    int b = wr_cnt;
    send_byte(8'h02); send_byte(8'h00);
    n_tests++; if (lnk.status !== 2'b01) begin n_fail++; $display("FAIL load_status act=%h exp=1", lnk.status); end
    send_byte(8'h34); send_byte(8'h12);
    n_tests++; if (lnk.com_wr_en !== 1'b1 || lnk.com_addr !== 16'h0000 || lnk.com_data_in !== 16'h1234) begin
      n_fail++; $display("FAIL write0 wr=%b addr=%h data=%h exp=1/0000/1234", lnk.com_wr_en, lnk.com_addr, lnk.com_data_in); end
    send_byte(8'hCD); send_byte(8'hAB);
    lnk.end_process = 1'b1;
    n_tests++; if (lnk.com_wr_en !== 1'b1 || lnk.com_addr !== 16'h0001 || lnk.com_data_in !== 16'hABCD) begin
      n_fail++; $display("FAIL write1 wr=%b addr=%h data=%h exp=1/0001/abcd", lnk.com_wr_en, lnk.com_addr, lnk.com_data_in); end
    @(negedge clk);
    n_tests++; if (lnk.status !== 2'b10) begin n_fail++; $display("FAIL run_status act=%h exp=2", lnk.status); end
    n_tests++; if (wr_cnt - b != 2) begin n_fail++; $display("FAIL load_wr_count act=%0d exp=2", wr_cnt - b); end
  endtask

  task automatic test_holdoff();
    int c = 0;
    n_tests++; if (lnk.com_wr_en !== 1'b0 || lnk.com_addr !== 16'h0001) begin n_fail++; $display("FAIL run_dm wr=%b addr=%h exp=0/0001", lnk.com_wr_en, lnk.com_addr); end
    while (lnk.status == 2'b10 && c < 20) begin c++; @(negedge clk); end
    n_tests++; if (c != 4) begin n_fail++; $display("FAIL holdoff_cycles act=%0d exp=4", c); end
    n_tests++; if (lnk.status !== 2'b11) begin n_fail++; $display("FAIL readback_status act=%h exp=3", lnk.status); end
  endtask

  task automatic test_readback();
    int tb0 = tx_cnt;
    int d0 = done_cnt;
    logic [7:0] exp_b [0:3];
    exp_b[0] = 8'h34; exp_b[1] = 8'h12; exp_b[2] = 8'hCD; exp_b[3] = 8'hAB;
    wait_done(500);
    n_tests++; if (lnk.status !== 2'b00) begin n_fail++; $display("FAIL fin_status act=%h exp=0", lnk.status); end
    lnk.end_process = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (tx_cnt - tb0 != 4) begin n_fail++; $display("FAIL tx_count act=%0d exp=4", tx_cnt - tb0); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (tx_log[(tb0 + i) % 16] !== exp_b[i]) begin n_fail++; $display("FAIL tx_byte%0d act=%h exp=%h", i, tx_log[(tb0 + i) % 16], exp_b[i]); end
    end
    n_tests++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL done_pulses act=%0d exp=1", done_cnt - d0); end
    n_tests++; if (lnk.rx_ready !== 1'b1 || lnk.status !== 2'b00) begin n_fail++; $display("FAIL back_idle rdy=%b st=%h exp=1/0", lnk.rx_ready, lnk.status); end
  endtask

  task automatic test_n_zero();
    int w0 = wr_cnt;
    int t0 = tx_cnt;
    int d0 = done_cnt;
    send_byte(8'h00); send_byte(8'h00);
    n_tests++; if (lnk.status !== 2'b10) begin n_fail++; $display("FAIL nz_status act=%h exp=2", lnk.status); end
    repeat (8) @(negedge clk);
    n_tests++; if (lnk.status !== 2'b10) begin n_fail++; $display("FAIL nz_wait_status act=%h exp=2", lnk.status); end
    lnk.end_process = 1'b1;
    wait_done(50);
    lnk.end_process = 1'b0;
    @(negedge clk);
    n_tests++; if (wr_cnt != w0 || tx_cnt != t0) begin n_fail++; $display("FAIL nz_traffic wr=%0d tx=%0d exp=0/0", wr_cnt - w0, tx_cnt - t0); end
    n_tests++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL nz_done act=%0d exp=1", done_cnt - d0); end
    n_tests++; if (lnk.status !== 2'b00 || lnk.rx_ready !== 1'b1) begin n_fail++; $display("FAIL nz_idle st=%h rdy=%b exp=0/1", lnk.status, lnk.rx_ready); end
  endtask

  task automatic test_wrap();
    int b = wr_cnt_b;
    send_byte_b(8'h02); send_byte_b(8'h00);
    send_byte_b(8'h11); send_byte_b(8'h11);
    send_byte_b(8'h22); send_byte_b(8'h22);
    repeat (3) @(negedge clk);
    n_tests++; if (wr_cnt_b - b != 2) begin n_fail++; $display("FAIL wrap_count act=%0d exp=2", wr_cnt_b - b); end
    n_tests++; if (wr_addr_b[b % 16] !== 16'hFFFF || wr_data_b[b % 16] !== 16'h1111) begin
      n_fail++; $display("FAIL wrap_w0 addr=%h data=%h exp=ffff/1111", wr_addr_b[b % 16], wr_data_b[b % 16]); end
    n_tests++; if (wr_addr_b[(b + 1) % 16] !== 16'h0000 || wr_data_b[(b + 1) % 16] !== 16'h2222) begin
      n_fail++; $display("FAIL wrap_w1 addr=%h data=%h exp=0000/2222", wr_addr_b[(b + 1) % 16], wr_data_b[(b + 1) % 16]); end
    n_tests++; if (lnk_b.status !== 2'b10) begin n_fail++; $display("FAIL wrap_status act=%h exp=2", lnk_b.status); end
  endtask

  task automatic test_reset_mid();
    int w0;
    int t0;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h77);
    w0 = wr_cnt;
    lnk.rx_valid = 1'b1; lnk.rx_data = 8'h88;
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (lnk.status !== 2'b00 || lnk.com_wr_en !== 1'b0 || lnk.tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst st=%h wr=%b txv=%b exp=0/0/0", lnk.status, lnk.com_wr_en, lnk.tx_valid); end
    n_tests++; if (lnk.rx_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_rdy act=%b exp=0", lnk.rx_ready); end
    lnk.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (wr_cnt != w0) begin n_fail++; $display("FAIL midrst_partial act=%0d exp=0", wr_cnt - w0); end
    send_byte(8'h01); send_byte(8'h00); send_byte(8'hEF); send_byte(8'hBE);
    @(negedge clk);
    n_tests++; if (wr_cnt - w0 != 1 || wr_addr[w0 % 16] !== 16'h0000 || wr_data[w0 % 16] !== 16'hBEEF) begin
      n_fail++; $display("FAIL reload cnt=%0d addr=%h data=%h exp=1/0000/beef", wr_cnt - w0, wr_addr[w0 % 16], wr_data[w0 % 16]); end
    t0 = tx_cnt;
    lnk.end_process = 1'b1;
    wait_done(300);
    lnk.end_process = 1'b0;
    @(negedge clk);
    n_tests++; if (tx_cnt - t0 != 2 || tx_log[t0 % 16] !== 8'hEF || tx_log[(t0 + 1) % 16] !== 8'hBE) begin
      n_fail++; $display("FAIL reload_tx cnt=%0d b0=%h b1=%h exp=2/ef/be", tx_cnt - t0, tx_log[t0 % 16], tx_log[(t0 + 1) % 16]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_holdoff();
    test_readback();
    test_n_zero();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/com_link_ctrl.md
Name: com_link_ctrl

Overview:
- Host-link controller sitting directly upstream of the quad-core top level.
- Converts a byte stream from the serial receiver into data-memory load writes, then sequences the global `status` word through LOAD, RUN and READBACK.
- Waits for the cores' aggregated `end_process`, then streams result words back to the serial transmitter.
- Owns `status`, `com_addr`, `com_data_in` and `com_wr_en`. Consumes `com_data_out` and `end_process`.

Parameters:
- LOAD_BASE, 16'h0000, first DM address written during load
- RD_BASE, 16'h0000, first DM address read during readback
- RD_LAT, 1, cycles from `com_addr` valid to `com_data_out` valid (1..3)
- RUN_HOLDOFF, 4, RUN cycles before `end_process` is honoured

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte accepted when rx_valid&rx_ready
- tx_data  out  8  byte to transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts when tx_valid&tx_ready
- status  out  2  00 IDLE, 01 LOAD, 10 RUN, 11 READBACK
- com_addr  out  16  DM address
- com_data_in  out  16  DM write data
- com_wr_en  out  1  DM write strobe
- com_data_out  in  16  DM read data
- end_process  in  1  all cores finished
- done  out  1  one-cycle pulse at end of transaction

Behaviour:
- Reset (async assert, sync release): state IDLE, status=00, com_addr=0, com_data_in=0, com_wr_en=0, rx_ready=0, tx_valid=0, tx_data=0, done=0, word count N=0, index=0.
- Reset mid-operation aborts everything; no partial write completes after rst_n falls.
- Frame format:
  - N as 16-bit little-endian (low byte first).
  - Then N data words, each low byte first.
  - Word k is written to LOAD_BASE+k, mod 2^16 wrap.
- States:
  - IDLE: rx_ready=1; first accepted byte -> N[7:0], go CNT_HI.
  - CNT_HI: rx_ready=1; accepted byte -> N[15:8]. N==0 -> RUN, else -> DAT_LO with status=01.
  - DAT_LO: rx_ready=1; accepted byte -> com_data_in[7:0], go DAT_HI.
  - DAT_HI: rx_ready=1; accepted byte -> com_data_in[15:8], go WRITE.
  - WRITE: rx_ready=0; com_wr_en=1 for exactly this one cycle with com_addr=LOAD_BASE+index; index++. Go DAT_LO if index<N, else RUN.
  - RUN: status=10, rx_ready=0; holdoff counter counts RUN_HOLDOFF cycles, and end_process is ignored during it. Afterwards, end_process==1 sampled -> index=0 and either RD_ADDR (N>0) or FIN (N==0).
  - RD_ADDR: status=11; com_addr=RD_BASE+index; wait RD_LAT cycles, capture com_data_out into a holding register, go TX_LO.
  - TX_LO: tx_valid=1, tx_data=hold[7:0]; on handshake go TX_HI.
  - TX_HI: tx_valid=1, tx_data=hold[15:8]; on handshake index++. index<N -> RD_ADDR, else FIN.
  - FIN: done=1 one cycle, status=00, -> IDLE.
- tx_valid/tx_data stable until handshake; tx_ready stalls indefinitely without data loss.
- rx_valid while rx_ready=0 is not consumed; the byte stays pending upstream.
- com_wr_en is never asserted outside WRITE.
- com_addr changes only on entry to WRITE or RD_ADDR; it holds its last value otherwise.
- N=16'hFFFF is legal: index is 17-bit internally, so there is no premature terminate.
- end_process already high on RUN entry is not honoured before the holdoff expires.

Decomposition:
- Shared package com_link_pkg:
  - status encodings ST_IDLE/ST_LOAD/ST_RUN/ST_READBACK
  - FSM state enum
  - byte/word width constants
- One sub-module, byte_word_pack: assembles the low/high byte pair into a 16-bit word and splits a word for TX, with its own lo/hi phase bit.

Test Plan:
- Load 2 words: bytes 02 00 34 12 CD AB -> com_wr_en pulses at addr 0 data 16'h1234, addr 1 data 16'hABCD; status 01 then 10.
- RUN with end_process=1 from entry, RUN_HOLDOFF=4 -> status stays 10 exactly 4 cycles, then 11.
- Readback N=2, com_data_out mem[0]=16'h1234, mem[1]=16'hABCD, tx_ready random -> tx bytes 34 12 CD AB in order; done pulses once; status 00.
- N=0 frame (00 00) -> no com_wr_en; status 10; after end_process, no tx bytes; done=1; return to IDLE.
- LOAD_BASE=16'hFFFF, N=2 -> writes at FFFF then 0000.
- rst_n low during DAT_HI -> next cycle status=00, com_wr_en=0, tx_valid=0; a fresh frame afterwards loads correctly from index 0.
